// File: rtl/led_pattern_gen.sv
`default_nettype none
// ============================================================================
// Module   : led_pattern_gen
// Brief    : Multi-channel LED pattern generator (OFF/ON/BLINK/PWM per channel)
//            with a shared prescaler tick and a valid/ready config port.
//            Optional macro LED_SYNC_EN adds sync_in to phase-align all channels.
// Revision : 1.0 - initial release
// ============================================================================
module led_pattern_gen #(
    parameter  int N_CH     = 4,
    parameter  int CNT_W    = 24,
    parameter  int TICK_DIV = 1,
    localparam int c_CH_W   = (N_CH > 1) ? $clog2(N_CH) : 1,
    localparam int c_SEL_W  = $clog2(CNT_W)
) (
    input  logic               clk_out1_0,
    input  logic               resetn,
`ifdef LED_SYNC_EN
    input  logic               sync_in,
`endif
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [c_CH_W-1:0]  cfg_ch,
    input  logic [1:0]         cfg_mode,
    input  logic [c_SEL_W-1:0] cfg_sel,
    input  logic [7:0]         cfg_duty,
    output logic               tick_o,
    output logic [N_CH-1:0]    led
);

    localparam int                 c_PS_W     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [c_PS_W-1:0]  c_PS_LAST  = c_PS_W'(TICK_DIV - 1);
    localparam logic [c_SEL_W-1:0] c_SEL_MAX  = c_SEL_W'(CNT_W - 1);
    localparam logic [1:0]         c_MODE_OFF = 2'b00;
    localparam logic [1:0]         c_MODE_ON  = 2'b01;
    localparam logic [1:0]         c_MODE_BLK = 2'b10;

    logic [c_PS_W-1:0]  r_presc;
    logic [c_PS_W-1:0]  w_presc_nxt;
    logic               r_tick;
    logic               r_ready;
    logic               w_acc;
    logic               w_sync;
    logic [c_SEL_W-1:0] w_sel_ld;

`ifdef LED_SYNC_EN
    assign w_sync = sync_in;
`else
    assign w_sync = 1'b0;
`endif

    assign w_acc     = cfg_valid && r_ready;
    assign w_sel_ld  = (int'(cfg_sel) >= CNT_W) ? c_SEL_MAX : cfg_sel;
    assign cfg_ready = r_ready;
    assign tick_o    = r_tick;

    always_comb begin
        w_presc_nxt = r_presc + 1'b1;
        if (w_sync || (r_presc == c_PS_LAST)) begin
            w_presc_nxt = '0;
        end
    end

    // tick is registered from the next prescaler value so it lines up with
    // the cycle in which the prescaler sits at its last count
    always_ff @(posedge clk_out1_0 or negedge resetn) begin
        if (!resetn) begin
            r_presc <= '0;
            r_tick  <= 1'b0;
            r_ready <= 1'b1;
        end else begin
            r_presc <= w_presc_nxt;
            r_tick  <= (w_presc_nxt == c_PS_LAST);
            r_ready <= !w_acc;
        end
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        logic [CNT_W-1:0]   r_cnt;
        logic [1:0]         r_mode;
        logic [c_SEL_W-1:0] r_sel;
        logic [7:0]         r_duty;
        logic               r_led;
        logic               w_hit;

        // out-of-range channel numbers never match, so such writes only ack
        assign w_hit  = w_acc && (cfg_ch == c_CH_W'(i));
        assign led[i] = r_led;

        always_ff @(posedge clk_out1_0 or negedge resetn) begin
            if (!resetn) begin
                r_cnt  <= '0;
                r_mode <= c_MODE_OFF;
                r_sel  <= '0;
                r_duty <= '0;
                r_led  <= 1'b0;
            end else begin
                if (w_hit) begin
                    r_mode <= cfg_mode;
                    r_sel  <= w_sel_ld;
                    r_duty <= cfg_duty;
                end
                if (w_sync || w_hit) begin
                    r_cnt <= '0;
                end else if (r_tick) begin
                    r_cnt <= r_cnt + 1'b1;
                end
                case (r_mode)
                    c_MODE_OFF: r_led <= 1'b0;
                    c_MODE_ON:  r_led <= 1'b1;
                    c_MODE_BLK: r_led <= r_cnt[r_sel];
                    default:    r_led <= (r_cnt[7:0] < r_duty);
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_led_pattern_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_led_pattern_gen
// Brief    : Randomized self-checking bench for led_pattern_gen against a
//            tick/phase-count reference model (N_CH=4, CNT_W=8, TICK_DIV=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_led_pattern_gen;

    localparam int c_N_CH     = 4;
    localparam int c_CNT_W    = 8;
    localparam int c_TICK_DIV = 4;

    logic       clk_out1_0 = 1'b0;
    logic       resetn     = 1'b0;
    logic       cfg_valid  = 1'b0;
    logic [1:0] cfg_ch     = '0;
    logic [1:0] cfg_mode   = '0;
    logic [2:0] cfg_sel    = '0;
    logic [7:0] cfg_duty   = '0;
    logic       cfg_ready;
    logic       tick_o;
    logic [3:0] led;
`ifdef LED_SYNC_EN
    logic       sync_in    = 1'b0;
`endif

    always #5 clk_out1_0 = ~clk_out1_0;

    led_pattern_gen #(
        .N_CH     (c_N_CH),
        .CNT_W    (c_CNT_W),
        .TICK_DIV (c_TICK_DIV)
    ) u_dut (
        .clk_out1_0 (clk_out1_0),
        .resetn     (resetn),
`ifdef LED_SYNC_EN
        .sync_in    (sync_in),
`endif
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_ch     (cfg_ch),
        .cfg_mode   (cfg_mode),
        .cfg_sel    (cfg_sel),
        .cfg_duty   (cfg_duty),
        .tick_o     (tick_o),
        .led        (led)
    );

    // Reference model: edges since release/sync, ticks since each channel clear
    int         m_n;
    bit         m_started;
    bit         m_ready;
    int         m_ph   [c_N_CH];
    int         m_mode [c_N_CH];
    int         m_sel  [c_N_CH];
    int         m_duty [c_N_CH];
    logic [3:0] m_led;

    int n_pass = 0;
    int n_chk  = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    endtask

    function automatic bit m_tick();
        return m_started && ((m_n % c_TICK_DIV) == (c_TICK_DIV - 1));
    endfunction

    function automatic bit m_led_of(input int c);
        case (m_mode[c])
            0:       return 1'b0;
            1:       return 1'b1;
            2:       return ((m_ph[c] >> m_sel[c]) & 1) != 0;
            default: return (m_ph[c] % 256) < m_duty[c];
        endcase
    endfunction

    task automatic model_reset();
        m_n = 0; m_started = 0; m_ready = 1; m_led = '0;
        for (int c = 0; c < c_N_CH; c++) begin
            m_ph[c] = 0; m_mode[c] = 0; m_sel[c] = 0; m_duty[c] = 0;
        end
    endtask

    // one clock: advance the model with the inputs present at the edge, then compare
    task automatic step();
        bit         acc;
        bit         tk;
        bit         sy;
        logic [3:0] nl;
        @(posedge clk_out1_0);
        acc = cfg_valid && m_ready;
        tk  = m_tick();
        sy  = 1'b0;
`ifdef LED_SYNC_EN
        sy  = sync_in;
`endif
        for (int c = 0; c < c_N_CH; c++) nl[c] = m_led_of(c);
        for (int c = 0; c < c_N_CH; c++) begin
            if (acc && (int'(cfg_ch) == c)) begin
                m_ph[c]   = 0;
                m_mode[c] = int'(cfg_mode);
                m_sel[c]  = (int'(cfg_sel) > c_CNT_W - 1) ? c_CNT_W - 1 : int'(cfg_sel);
                m_duty[c] = int'(cfg_duty);
            end else if (tk) begin
                m_ph[c] = (m_ph[c] + 1) % (1 << c_CNT_W);
            end
            if (sy) m_ph[c] = 0;
        end
        m_led     = nl;
        m_ready   = !acc;
        m_started = 1;
        m_n       = sy ? 0 : m_n + 1;
        #1;
        check_eq("led", led, m_led);
        check_eq("tick_o", tick_o, m_tick());
        check_eq("cfg_ready", cfg_ready, m_ready);
    endtask

    task automatic cfg_write(input int ch, input int mode, input int sel, input int duty);
        bit was_ready;
        cfg_valid = 1'b1;
        cfg_ch    = 2'(ch);
        cfg_mode  = 2'(mode);
        cfg_sel   = 3'(sel);
        cfg_duty  = 8'(duty);
        for (int k = 0; k < 4; k++) begin
            was_ready = m_ready;
            step();
            if (was_ready) break;
        end
        cfg_valid = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int hi;
        int acc_cnt;
        bit found;

        model_reset();
        repeat (3) @(posedge clk_out1_0);
        #2;
        check_eq("rst_led", led, 4'b0000);
        check_eq("rst_ready", cfg_ready, 1'b1);
        check_eq("rst_tick", tick_o, 1'b0);
        @(negedge clk_out1_0);
        resetn = 1'b1;

        // first tick lands in the fourth cycle after release
        repeat (3) step();
        check_eq("first_tick", tick_o, 1'b1);
        repeat (9) step();

        cfg_write(1, 1, 0, 0);
        check_eq("ready_drop", cfg_ready, 1'b0);
        step();
        check_eq("on_led", led, 4'b0010);

        cfg_write(0, 2, 0, 0);
        repeat (40) step();
        cfg_write(0, 2, 2, 0);
        repeat (80) step();

        cfg_write(2, 3, 0, 64);
        step();
        hi = 0;
        for (int k = 0; k < 1024; k++) begin
            step();
            hi += int'(led[2]);
        end
        check_eq("pwm64_high", hi, 256);

        cfg_write(2, 3, 0, 0);
        step();
        hi = 0;
        for (int k = 0; k < 1024; k++) begin
            step();
            hi += int'(led[2]);
        end
        check_eq("pwm0_high", hi, 0);

        // write landing on a tick edge must leave the counter at 0
        found = 0;
        for (int k = 0; k < 16 && !found; k++) begin
            step();
            if (tick_o) found = 1;
        end
        check_eq("tick_wait", found, 1'b1);
        cfg_write(3, 2, 0, 0);
        repeat (4) step();
        check_eq("tick_write_cnt0", led[3], 1'b0);

        // valid held high: one accept every second cycle
        cfg_valid = 1'b1;
        acc_cnt   = 0;
        for (int k = 0; k < 10; k++) begin
            cfg_ch   = 2'($urandom);
            cfg_mode = 2'($urandom);
            cfg_sel  = 3'($urandom);
            cfg_duty = 8'($urandom);
            if (cfg_ready) acc_cnt++;
            step();
        end
        cfg_valid = 1'b0;
        check_eq("held_valid_accepts", acc_cnt, 5);

        for (int k = 0; k < 2000; k++) begin
            cfg_valid = ($urandom % 4) == 0;
            cfg_ch    = 2'($urandom);
            cfg_mode  = 2'($urandom);
            cfg_sel   = 3'($urandom);
            cfg_duty  = 8'($urandom);
`ifdef LED_SYNC_EN
            sync_in   = ($urandom % 64) == 0;
`endif
            step();
        end
        cfg_valid = 1'b0;
`ifdef LED_SYNC_EN
        sync_in   = 1'b0;
`endif

        // asynchronous reset in the middle of a blink, away from any edge
        cfg_write(0, 2, 0, 0);
        cfg_write(1, 1, 0, 0);
        repeat (6) step();
        check_eq("pre_reset_on", led[1], 1'b1);
        #3;
        resetn = 1'b0;
        #1;
        check_eq("async_rst_led", led, 4'b0000);
        check_eq("async_rst_ready", cfg_ready, 1'b1);
        model_reset();
        @(negedge clk_out1_0);
        #2;
        resetn = 1'b1;
        repeat (20) step();
        check_eq("modes_off_after_rst", led, 4'b0000);

`ifdef LED_SYNC_EN
        cfg_write(0, 2, 0, 0);
        repeat (5) step();
        cfg_write(1, 2, 0, 0);
        repeat (6) step();
        sync_in = 1'b1;
        step();
        sync_in = 1'b0;
        repeat (5) step();
        for (int k = 0; k < 20; k++) begin
            step();
            check_eq("sync_aligned", led[1], led[0]);
        end
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
